rsa_operand_loader: RTL

Byte-serial front end for `rsa_unit` that carries operands in and the result out. It collects the four operand bytes P, E, M and Const, in that fixed order, over a valid/ready handshake. It then clears and starts the core, waits for `eoc` under a cycle watchdog, and holds the ciphertext C until the host acknowledges it. The block sits between the top-level pin interface and `rsa_unit`, so operands no longer share a single `ui_in` bus.

---
 rtl/rsa_operand_loader.sv | 108 ++++++++++
 1 files changed

// File: rtl/rsa_operand_loader.sv
// Byte-serial front end for rsa_unit: loads P/E/M/Const over valid/ready, pulses the
// core reset, runs the core under a cycle watchdog and holds C until acknowledged.
module rsa_operand_loader #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  input  logic       abort,
  output logic [7:0] core_p,
  output logic [7:0] core_e,
  output logic [7:0] core_m,
  output logic [7:0] core_const,
  output logic       core_en,
  output logic       core_rstb,
  input  logic       core_eoc,
  input  logic [7:0] core_c,
  output logic [7:0] result,
  output logic       result_valid,
  input  logic       result_ack,
  output logic       timeout_err,
  output logic       busy
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {LD_P, LD_E, LD_M, LD_C, CLR, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             take, run_eoc, run_tmo;

  // abort outranks every other event, so it also vetoes a byte handshake
  assign take    = din_valid && din_ready && !abort;
  assign run_eoc = (state == RUN) && core_eoc;
  assign run_tmo = (state == RUN) && !core_eoc && (cnt == CNT_LAST);

  always_comb begin
    // NOTE: default assigned first so every path drives state_nx and no latch is inferred.
    state_nx = state;
    unique case (state)
      LD_P:    if (take) state_nx = LD_E;
      LD_E:    if (take) state_nx = LD_M;
      LD_M:    if (take) state_nx = LD_C;
      LD_C:    if (take) state_nx = CLR;
      CLR:     state_nx = RUN;
      RUN:     if (run_eoc || run_tmo) state_nx = DONE;
      DONE:    if (result_ack) state_nx = LD_P;
      default: state_nx = LD_P;
    endcase
    if (abort) state_nx = LD_P;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LD_P;
      core_p      <= '0;
      core_e      <= '0;
      core_m      <= '0;
      core_const  <= '0;
      cnt         <= '0;
      result      <= '0;
      timeout_err <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every register samples pre-edge values.
      state <= state_nx;

      if (take) begin
        case (state)
          LD_P:    core_p     <= din;
          LD_E:    core_e     <= din;
          LD_M:    core_m     <= din;
          LD_C:    core_const <= din;
          default: ;
        endcase
      end

      // saturating so the watchdog can never wrap back to a legal count
      if (state == CLR) begin
        cnt <= '0;
      end else if (state == RUN && !core_eoc && cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end

      // eoc beats the watchdog when both land on the same cycle
      if (!abort) begin
        if (run_eoc) begin
          result      <= core_c;
          timeout_err <= 1'b0;
        end else if (run_tmo) begin
          result      <= '0;
          timeout_err <= 1'b1;
        end
      end
    end
  end

  assign din_ready    = (state == LD_P) || (state == LD_E) || (state == LD_M) || (state == LD_C);
  assign core_en      = (state == RUN);
  assign core_rstb    = (state != CLR);
  assign result_valid = (state == DONE);
  assign busy         = (state == CLR) || (state == RUN);

endmodule
